lvds_axi_burst_bridge: RTL and testbench
========================================

Name: lvds_axi_burst_bridge

Overview:
- Parametrised successor of the Parallella LVDS controller.
- Decodes typed word frames from the SerDes receiver (command, address, data) and issues one AXI4 INCR burst per frame: write of 1..MAX_BURST beats, or read of 1..MAX_BURST beats.
- Returns read data and a status word to the SerDes transmitter through a ready/valid interface.
- Sits between the LVDS SerDes pair and the AXI full-master port.

Parameters:
- DATA_W, 32, AXI data and SerDes payload width (32 or 64).
- ADDR_W, 32, AXI address width (at most DATA_W).
- MAX_BURST, 16, buffer depth and maximum beats per frame (power of 2, 2..256).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one received word this cycle; no backpressure.
- rx_type  in  2  word type: 00 CMD, 01 ADDR, 10 DATA, 11 CRC.
- rx_word  in  DATA_W  received payload.
- tx_valid  out  1  word offered to the SerDes transmitter.
- tx_ready  in  1  transmitter accepts the word (the old !lvds_busy).
- tx_type  out  2  same encoding as rx_type; CMD carries the status word.
- tx_word  out  DATA_W  transmit payload.
- m_awaddr/m_awlen/m_awvalid/m_awready  out/out/out/in  ADDR_W/8/1/1  AXI AW channel.
- m_wdata/m_wstrb/m_wlast/m_wvalid/m_wready  out/out/out/out/in  DATA_W/DATA_W/8/1/1/1  AXI W channel.
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI B channel.
- m_araddr/m_arlen/m_arvalid/m_arready  out/out/out/in  ADDR_W/8/1/1  AXI AR channel.
- m_rdata/m_rresp/m_rlast/m_rvalid/m_rready  in/in/in/in/out  DATA_W/2/1/1/1  AXI R channel.
- m_axsize/m_axburst  out  3/2  constant log2(DATA_W/8) and INCR; wstrb is all ones.
- err_count  out  8  saturating count of protocol errors.

Behaviour:
- CMD word fields: [7:0] len-1, [9:8] op (01 WRITE, 10 READ), [15:12] tag.
- Reset: all valids and m_bready/m_rready low, tx outputs 0, err_count 0, state IDLE. Reset during a frame aborts it with no AXI or tx activity afterwards.
- IDLE:
  - CMD with a legal op and len-1 < MAX_BURST latches the command and moves to GET_ADDR.
  - Any other word is dropped and err_count increments.
- GET_ADDR:
  - ADDR latches rx_word[ADDR_W-1:0]; WRITE goes to GET_DATA, READ goes to AR.
  - Any other type goes to ERR.
- GET_DATA:
  - Each DATA word is written to the buffer at wr_ptr.
  - After len beats, go to AW.
  - Non-DATA type goes to ERR.
- AW: m_awvalid held until m_awready; m_awlen = len-1; then W.
- W:
  - Stream the buffer; m_wlast on beat len-1. Advance only on m_wvalid and m_wready.
  - The first W beat is never presented before the AW handshake completes.
- B: m_bready=1; latch m_bresp on m_bvalid; go to RESP.
- AR: m_arvalid held until m_arready; then R.
- R:
  - m_rready=1; beats stored in the buffer; the worst m_rresp is kept.
  - m_rlast or beat count == len moves to SEND. An m_rlast earlier than len is a protocol error; a missing one is treated as m_rlast at beat len.
- SEND: offer DATA words from the buffer; advance on tx_valid and tx_ready. tx_word stays stable while tx_ready is low.
- RESP:
  - Offer a CMD-type status word: [1:0] resp, [3:2] 00 ok / 01 protocol error / 10 CRC error, [9:8] op, [15:12] tag.
  - On tx_ready, go to IDLE.
- ERR: increment err_count, issue status with code 01, then IDLE. No AXI transaction is started.
- rx words arriving in AW/W/B/AR/R/SEND/RESP/ERR are dropped and counted.
- Latency: AW is asserted 1 cycle after the last DATA word; the status word 1 cycle after the B or R completion (or after the last SEND word).

Optional Feature:
- LVDS_BRIDGE_CRC_EN defined:
  - In GET_DATA, CRC-16-CCITT (init 0xFFFF) is computed over the data words, LSB byte first.
  - After len data words, one CRC word is expected (rx_word[15:0]).
  - On mismatch: no AXI write; status code 10.
  - For reads, a CRC-type word follows the last SEND word.
- Undefined: no CRC words are expected or sent, and a CRC-type rx word is a protocol error.

Decomposition:
- Package lvds_bridge_pkg holds:
  - word-type encodings,
  - opcodes,
  - status code constants,
  - CMD and status field offsets,
  - state encodings.
- Sub-module lvds_bridge_crc16: byte-serial CRC-16 update with a DATA_W-wide input, combinational next value plus a registered accumulator.
- The buffer is an inferred RAM inside the top module.

Test Plan:
- Write: CMD len-1=3 op=01 tag=5, ADDR 0x4000_0010, DATA 1..4 -> AW addr 0x4000_0010 len 3; 4 W beats 1..4, wlast on the 4th; status 0x5100 after bresp=00.
- Read: CMD len-1=15 op=10, ADDR 0x4000_0000, slave returns 0xA0..0xAF -> 16 DATA tx words in order, then status 0x0200. Hold tx_ready low 5 cycles mid-stream -> no word lost or duplicated.
- Protocol error: CMD then DATA instead of ADDR -> no AXI valids, status code 01, err_count 1. CMD with len-1=20 at MAX_BURST=16 -> dropped, err_count increments.
- AXI error: bresp=10 on a write -> status [1:0]=10. One read beat with rresp=11 -> status resp=11.
- Reset asserted during the W state -> all valids low within 0 cycles; after release a new 1-beat write completes normally.
- LVDS_BRIDGE_CRC_EN: correct CRC -> write proceeds; corrupted CRC -> no awvalid, status code 10.

Source files
------------

// File: rtl/lvds_bridge_pkg.sv
// lvds_bridge_pkg: shared encodings for the LVDS SerDes <-> AXI4 burst bridge.
// Word types, opcodes, status codes, CMD/status field offsets and FSM states.
package lvds_bridge_pkg;
    localparam logic [1:0] T_CMD  = 2'b00;
    localparam logic [1:0] T_ADDR = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_CRC  = 2'b11;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_PROTO = 2'b01;
    localparam logic [1:0] CODE_CRC   = 2'b10;

    localparam int CMD_LEN_LSB  = 0;
    localparam int CMD_OP_LSB   = 8;
    localparam int CMD_TAG_LSB  = 12;
    localparam int STS_RESP_LSB = 0;
    localparam int STS_CODE_LSB = 2;
    localparam int STS_OP_LSB   = 8;
    localparam int STS_TAG_LSB  = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_CRC, S_AW, S_W, S_B,
        S_AR, S_R, S_SEND, S_SEND_CRC, S_RESP, S_ERR
    } state_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
endpackage

// File: rtl/lvds_bridge_crc16.sv
// lvds_bridge_crc16: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over a DATA_W word,
// bytes taken LSB first; combinational next value plus registered accumulator.
module lvds_bridge_crc16 #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [15:0]       o_crc,
    output logic [15:0]       o_crc_next
);
    logic [15:0] r_crc;

    always_comb begin
        o_crc_next = r_crc;
        for (int b = 0; b < DATA_W / 8; b++) begin
            o_crc_next = o_crc_next ^ {i_data[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++)
                o_crc_next = o_crc_next[15] ? ({o_crc_next[14:0], 1'b0} ^ 16'h1021) : {o_crc_next[14:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_crc <= 16'hFFFF;
        else if (i_init) r_crc <= 16'hFFFF;
        else if (i_en)   r_crc <= o_crc_next;
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/lvds_axi_burst_bridge.sv
// lvds_axi_burst_bridge: decodes CMD/ADDR/DATA frames from the SerDes into one AXI4
// INCR burst each and returns read data and status; CRC framing via LVDS_BRIDGE_CRC_EN.
module lvds_axi_burst_bridge
    import lvds_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx_valid,
    input  logic [1:0]          i_rx_type,
    input  logic [DATA_W-1:0]   i_rx_word,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic [1:0]          o_tx_type,
    output logic [DATA_W-1:0]   o_tx_word,
    output logic [ADDR_W-1:0]   o_m_awaddr,
    output logic [7:0]          o_m_awlen,
    output logic                o_m_awvalid,
    input  logic                i_m_awready,
    output logic [DATA_W-1:0]   o_m_wdata,
    output logic [DATA_W/8-1:0] o_m_wstrb,
    output logic                o_m_wlast,
    output logic                o_m_wvalid,
    input  logic                i_m_wready,
    input  logic [1:0]          i_m_bresp,
    input  logic                i_m_bvalid,
    output logic                o_m_bready,
    output logic [ADDR_W-1:0]   o_m_araddr,
    output logic [7:0]          o_m_arlen,
    output logic                o_m_arvalid,
    input  logic                i_m_arready,
    input  logic [DATA_W-1:0]   i_m_rdata,
    input  logic [1:0]          i_m_rresp,
    input  logic                i_m_rlast,
    input  logic                i_m_rvalid,
    output logic                o_m_rready,
    output logic [2:0]          o_m_axsize,
    output logic [1:0]          o_m_axburst,
    output logic [7:0]          o_err_count
);
`ifdef LVDS_BRIDGE_CRC_EN
    localparam logic CRC_EN = 1'b1;
`else
    localparam logic CRC_EN = 1'b0;
`endif
    localparam int         PTR_W = $clog2(MAX_BURST);
    localparam logic [8:0] MAXB  = 9'(MAX_BURST);

    state_t              r_state, w_next;
    logic [1:0]          r_op, r_resp, r_code, w_err_inc;
    logic [3:0]          r_tag;
    logic [7:0]          r_len_m1, r_err_count;
    logic [8:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mem [MAX_BURST];
    logic [DATA_W-1:0]   w_mem_rd, w_mem_wd, w_status;
    logic [15:0]         w_crc, w_crc_next;
    logic                w_cmd_ok, w_last, w_mem_we, w_crc_en, w_drop, w_early;

    assign w_cmd_ok = i_rx_type == T_CMD
                   && (i_rx_word[CMD_OP_LSB +: 2] == OP_WRITE || i_rx_word[CMD_OP_LSB +: 2] == OP_READ)
                   && {1'b0, i_rx_word[CMD_LEN_LSB +: 8]} < MAXB;
    assign w_last   = r_cnt == {1'b0, r_len_m1};
    assign w_mem_rd = r_mem[r_cnt[PTR_W-1:0]];
    assign w_mem_we = (r_state == S_GET_DATA && i_rx_valid && i_rx_type == T_DATA) || (r_state == S_R && i_m_rvalid);
    assign w_mem_wd = r_state == S_R ? i_m_rdata : i_rx_word;
    assign w_crc_en = (r_state == S_GET_DATA && i_rx_valid && i_rx_type == T_DATA) || (r_state == S_SEND && i_tx_ready);
    assign w_early  = r_state == S_R && i_m_rvalid && i_m_rlast && !w_last;
    assign w_drop   = i_rx_valid && (r_state == S_IDLE ? !w_cmd_ok
                    : !(r_state == S_GET_ADDR || r_state == S_GET_DATA || r_state == S_GET_CRC));
    assign w_err_inc = {1'b0, w_drop} + {1'b0, r_state == S_ERR} + {1'b0, w_early};

    lvds_bridge_crc16 #(.DATA_W(DATA_W)) u_crc (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_init     (r_state == S_IDLE && i_rx_valid && w_cmd_ok),
        .i_en       (w_crc_en),
        .i_data     (r_state == S_SEND ? w_mem_rd : i_rx_word),
        .o_crc      (w_crc),
        .o_crc_next (w_crc_next)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (i_rx_valid && w_cmd_ok) w_next = S_GET_ADDR;
            S_GET_ADDR: if (i_rx_valid) w_next = i_rx_type != T_ADDR ? S_ERR : r_op == OP_WRITE ? S_GET_DATA : S_AR;
            S_GET_DATA: if (i_rx_valid) w_next = i_rx_type != T_DATA ? S_ERR : !w_last ? S_GET_DATA : CRC_EN ? S_GET_CRC : S_AW;
            S_GET_CRC:  if (i_rx_valid) w_next = i_rx_type != T_CRC ? S_ERR : i_rx_word[15:0] == w_crc ? S_AW : S_RESP;
            S_AW:       if (i_m_awready) w_next = S_W;
            S_W:        if (i_m_wready && w_last) w_next = S_B;
            S_B:        if (i_m_bvalid) w_next = S_RESP;
            S_AR:       if (i_m_arready) w_next = S_R;
            S_R:        if (i_m_rvalid && (i_m_rlast || w_last)) w_next = S_SEND;
            S_SEND:     if (i_tx_ready && w_last) w_next = CRC_EN ? S_SEND_CRC : S_RESP;
            S_SEND_CRC: if (i_tx_ready) w_next = S_RESP;
            S_RESP:     if (i_tx_ready) w_next = S_IDLE;
            S_ERR:      w_next = S_RESP;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_status = '0;
        w_status[STS_RESP_LSB +: 2] = r_resp;
        w_status[STS_CODE_LSB +: 2] = r_code;
        w_status[STS_OP_LSB +: 2]   = r_op;
        w_status[STS_TAG_LSB +: 4]  = r_tag;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[r_cnt[PTR_W-1:0]] <= w_mem_wd;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op        <= '0;
            r_tag       <= '0;
            r_len_m1    <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_resp      <= '0;
            r_code      <= CODE_OK;
            r_err_count <= '0;
        end else begin
            r_err_count <= sat_add(r_err_count, w_err_inc);
            case (r_state)
                S_IDLE: if (i_rx_valid && w_cmd_ok) begin
                    r_op     <= i_rx_word[CMD_OP_LSB +: 2];
                    r_tag    <= i_rx_word[CMD_TAG_LSB +: 4];
                    r_len_m1 <= i_rx_word[CMD_LEN_LSB +: 8];
                    r_cnt    <= '0;
                    r_resp   <= '0;
                    r_code   <= CODE_OK;
                end
                S_GET_ADDR: if (i_rx_valid && i_rx_type == T_ADDR) r_addr <= i_rx_word[ADDR_W-1:0];
                S_GET_DATA: if (i_rx_valid && i_rx_type == T_DATA) r_cnt <= w_last ? '0 : r_cnt + 9'd1;
                S_GET_CRC:  if (i_rx_valid && i_rx_type == T_CRC && i_rx_word[15:0] != w_crc) r_code <= CODE_CRC;
                S_W:        if (i_m_wready) r_cnt <= w_last ? '0 : r_cnt + 9'd1;
                S_B:        if (i_m_bvalid) r_resp <= i_m_bresp;
                S_R: if (i_m_rvalid) begin
                    r_cnt  <= (i_m_rlast || w_last) ? '0 : r_cnt + 9'd1;
                    r_resp <= i_m_rresp > r_resp ? i_m_rresp : r_resp;
                    // a short burst shrinks the frame so SEND returns only what arrived
                    if (w_early) begin
                        r_code   <= CODE_PROTO;
                        r_len_m1 <= r_cnt[7:0];
                    end
                end
                S_SEND:     if (i_tx_ready) r_cnt <= w_last ? '0 : r_cnt + 9'd1;
                S_ERR:      r_code <= CODE_PROTO;
                default:    ;
            endcase
        end
    end

    assign o_tx_valid  = r_state == S_SEND || r_state == S_SEND_CRC || r_state == S_RESP;
    assign o_tx_type   = r_state == S_SEND ? T_DATA : r_state == S_SEND_CRC ? T_CRC : T_CMD;
    assign o_tx_word   = r_state == S_SEND ? w_mem_rd
                       : r_state == S_SEND_CRC ? {{(DATA_W-16){1'b0}}, w_crc}
                       : r_state == S_RESP ? w_status : '0;
    assign o_m_awaddr  = r_addr;
    assign o_m_awlen   = r_len_m1;
    assign o_m_awvalid = r_state == S_AW;
    assign o_m_wdata   = w_mem_rd;
    assign o_m_wstrb   = '1;
    assign o_m_wlast   = r_state == S_W && w_last;
    assign o_m_wvalid  = r_state == S_W;
    assign o_m_bready  = r_state == S_B;
    assign o_m_araddr  = r_addr;
    assign o_m_arlen   = r_len_m1;
    assign o_m_arvalid = r_state == S_AR;
    assign o_m_rready  = r_state == S_R;
    assign o_m_axsize  = 3'($clog2(DATA_W / 8));
    assign o_m_axburst = 2'b01;
    assign o_err_count = r_err_count;
endmodule

// File: tb/tb_lvds_axi_burst_bridge.sv
// tb_lvds_axi_burst_bridge: directed frame table plus hand-written corner sequences
// for the LVDS/AXI burst bridge; follows LVDS_BRIDGE_CRC_EN when defined.
module tb_lvds_axi_burst_bridge;
    localparam logic [1:0] TC = 2'b00, TA = 2'b01, TD = 2'b10, TK = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  lm1;
        logic [3:0]  tag;
        logic [31:0] addr;
        logic [31:0] dbase;
        logic [1:0]  resp;
        int          rl;
        bit          stall;
        logic [31:0] status;
        int          err;
    } frame_t;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] w;
    } drop_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic rx_valid = 1'b0, tx_ready = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
    logic [1:0] rx_type = '0, bresp = '0, rresp = '0;
    logic [31:0] rx_word = '0, rdata = '0;
    logic tx_valid, awvalid, wlast, wvalid, bready, arvalid, rready;
    logic [1:0] tx_type, axburst;
    logic [2:0] axsize;
    logic [3:0] wstrb;
    logic [7:0] awlen, arlen, err_count;
    logic [31:0] tx_word, awaddr, wdata, araddr;

    int n_chk = 0, n_err = 0, exp_err = 0;
    frame_t frames[7];
    drop_t  drops[7];

    always #5 clk = ~clk;

    lvds_axi_burst_bridge dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_valid(rx_valid), .i_rx_type(rx_type), .i_rx_word(rx_word),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_type(tx_type), .o_tx_word(tx_word),
        .o_m_awaddr(awaddr), .o_m_awlen(awlen), .o_m_awvalid(awvalid), .i_m_awready(awready),
        .o_m_wdata(wdata), .o_m_wstrb(wstrb), .o_m_wlast(wlast), .o_m_wvalid(wvalid), .i_m_wready(wready),
        .i_m_bresp(bresp), .i_m_bvalid(bvalid), .o_m_bready(bready),
        .o_m_araddr(araddr), .o_m_arlen(arlen), .o_m_arvalid(arvalid), .i_m_arready(arready),
        .i_m_rdata(rdata), .i_m_rresp(rresp), .i_m_rlast(rlast), .i_m_rvalid(rvalid), .o_m_rready(rready),
        .o_m_axsize(axsize), .o_m_axburst(axburst), .o_err_count(err_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_rx(input logic [1:0] t, input logic [31:0] w);
        rx_valid = 1'b1;
        rx_type  = t;
        rx_word  = w;
        step();
        rx_valid = 1'b0;
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] d);
        logic [15:0] x;
        x = c;
        for (int b = 0; b < 4; b++) begin
            x = x ^ {d[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) x = x[15] ? ({x[14:0], 1'b0} ^ 16'h1021) : {x[14:0], 1'b0};
        end
        return x;
    endfunction

    task automatic finish_status(input logic [31:0] status, input int err);
        chk1("status_valid", tx_valid, 1'b1);
        chk("status_type", {30'd0, tx_type}, {30'd0, TC});
        chk("status_word", tx_word, status);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk1("idle_tx_valid", tx_valid, 1'b0);
        exp_err += err;
        chk("err_count", {24'd0, err_count}, 32'(exp_err));
    endtask

    task automatic run_frame(input frame_t f);
        int nb;
        logic [15:0] crc;
        crc = 16'hFFFF;
        send_rx(TC, {16'h0, f.tag, 2'b00, f.op, f.lm1});
        send_rx(TA, f.addr);
        if (f.op == 2'b01) begin
            for (int i = 0; i <= int'(f.lm1); i++) begin
                send_rx(TD, f.dbase + 32'(i));
                crc = crc_upd(crc, f.dbase + 32'(i));
            end
`ifdef LVDS_BRIDGE_CRC_EN
            send_rx(TK, {16'h0, crc});
`endif
            chk1("awvalid_latency", awvalid, 1'b1);
            chk("awaddr", awaddr, f.addr);
            chk("awlen", {24'd0, awlen}, {24'd0, f.lm1});
            chk("axsize", {29'd0, axsize}, 32'd2);
            chk("axburst", {30'd0, axburst}, 32'd1);
            chk1("wvalid_before_aw", wvalid, 1'b0);
            step();
            chk1("awvalid_hold", awvalid, 1'b1);
            chk1("wvalid_before_aw2", wvalid, 1'b0);
            awready = 1'b1;
            step();
            awready = 1'b0;
            chk1("awvalid_done", awvalid, 1'b0);
            chk("wstrb", {28'd0, wstrb}, 32'hF);
            for (int i = 0; i <= int'(f.lm1); i++) begin
                if (i == 1) begin
                    wready = 1'b0;
                    step();
                    chk("wdata_stall", wdata, f.dbase + 32'(i));
                end
                chk1("wvalid", wvalid, 1'b1);
                chk("wdata", wdata, f.dbase + 32'(i));
                chk1("wlast", wlast, i == int'(f.lm1));
                wready = 1'b1;
                step();
                wready = 1'b0;
            end
            chk1("bready", bready, 1'b1);
            chk1("wvalid_after", wvalid, 1'b0);
            bresp  = f.resp;
            bvalid = 1'b1;
            step();
            bvalid = 1'b0;
            bresp  = 2'b00;
        end else begin
            chk1("arvalid_latency", arvalid, 1'b1);
            chk("araddr", araddr, f.addr);
            chk("arlen", {24'd0, arlen}, {24'd0, f.lm1});
            chk1("rready_before_ar", rready, 1'b0);
            arready = 1'b1;
            step();
            arready = 1'b0;
            nb = f.rl >= 0 ? f.rl + 1 : int'(f.lm1) + 1;
            for (int i = 0; i < nb; i++) begin
                chk1("rready", rready, 1'b1);
                rvalid = 1'b1;
                rdata  = f.dbase + 32'(i);
                rresp  = i == 0 ? f.resp : 2'b00;
                rlast  = i == f.rl;
                step();
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            chk1("rready_after", rready, 1'b0);
            for (int i = 0; i < nb; i++) begin
                chk1("send_valid", tx_valid, 1'b1);
                chk("send_type", {30'd0, tx_type}, {30'd0, TD});
                chk("send_word", tx_word, f.dbase + 32'(i));
                if (f.stall && i == 8) begin
                    for (int s = 0; s < 5; s++) begin
                        step();
                        chk("send_word_stall", tx_word, f.dbase + 32'(i));
                    end
                end
                crc = crc_upd(crc, f.dbase + 32'(i));
                tx_ready = 1'b1;
                step();
                tx_ready = 1'b0;
            end
`ifdef LVDS_BRIDGE_CRC_EN
            chk("send_crc_type", {30'd0, tx_type}, {30'd0, TK});
            chk("send_crc_word", tx_word, {16'h0, crc});
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
`endif
        end
        finish_status(f.status, f.err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        frames[0] = '{2'b01, 8'd3,  4'h5, 32'h4000_0010, 32'h0000_0001, 2'b00, 0,  1'b0, 32'h5100, 0};
        frames[1] = '{2'b10, 8'd15, 4'h0, 32'h4000_0000, 32'h0000_00A0, 2'b00, 15, 1'b1, 32'h0200, 0};
        frames[2] = '{2'b01, 8'd0,  4'h3, 32'h1000_0000, 32'h1234_5678, 2'b10, 0,  1'b0, 32'h3102, 0};
        frames[3] = '{2'b10, 8'd1,  4'h7, 32'h2000_0040, 32'hCAFE_0000, 2'b11, 1,  1'b0, 32'h7203, 0};
        frames[4] = '{2'b10, 8'd3,  4'h9, 32'h2000_0100, 32'h0000_0B00, 2'b00, 1,  1'b0, 32'h9204, 1};
        frames[5] = '{2'b10, 8'd2,  4'hA, 32'h2000_0200, 32'h0000_0C00, 2'b00, -1, 1'b0, 32'hA200, 0};
        frames[6] = '{2'b01, 8'd15, 4'hF, 32'hFFFF_FFC0, 32'hDEAD_0000, 2'b00, 0,  1'b0, 32'hF100, 0};
        drops[0] = '{TC, 32'h0000_0003};
        drops[1] = '{TC, 32'h0000_0300};
        drops[2] = '{TC, 32'h0000_0114};
        drops[3] = '{TC, 32'h0000_0210};
        drops[4] = '{TA, 32'h4000_0000};
        drops[5] = '{TD, 32'h0000_0001};
        drops[6] = '{TK, 32'h0000_FFFF};

        step();
        step();
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_word", tx_word, 32'h0);
        chk("rst_tx_type", {30'd0, tx_type}, 32'd0);
        chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 7; n++) run_frame(frames[n]);

        for (int n = 0; n < 7; n++) begin
            send_rx(drops[n].t, drops[n].w);
            exp_err++;
            chk("drop_err_count", {24'd0, err_count}, 32'(exp_err));
            chk("drop_no_activity", {29'd0, tx_valid, awvalid, arvalid}, 32'd0);
        end

        send_rx(TC, 32'h0000_2100);
        send_rx(TD, 32'h0000_0055);
        chk("proto_no_axi", {29'd0, awvalid, arvalid, tx_valid}, 32'd0);
        step();
        chk("proto_no_axi_resp", {30'd0, awvalid, arvalid}, 32'd0);
        finish_status(32'h2104, 1);

`ifdef LVDS_BRIDGE_CRC_EN
        send_rx(TC, 32'h0000_4101);
        send_rx(TA, 32'h3000_0000);
        send_rx(TD, 32'h0000_0011);
        send_rx(TD, 32'h0000_0022);
        send_rx(TK, {16'h0, ~crc_upd(crc_upd(16'hFFFF, 32'h11), 32'h22)});
        chk1("crc_bad_no_aw", awvalid, 1'b0);
        finish_status(32'h4108, 0);
`endif

        send_rx(TC, 32'h0000_1103);
        send_rx(TA, 32'h5000_0000);
        for (int i = 0; i < 4; i++) send_rx(TD, 32'h0000_0070 + 32'(i));
`ifdef LVDS_BRIDGE_CRC_EN
        send_rx(TK, {16'h0, crc_upd(crc_upd(crc_upd(crc_upd(16'hFFFF, 32'h70), 32'h71), 32'h72), 32'h73)});
`endif
        chk1("busy_aw", awvalid, 1'b1);
        send_rx(TD, 32'h0000_0099);
        exp_err++;
        chk("busy_drop_err", {24'd0, err_count}, 32'(exp_err));
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk1("rst_pre_wvalid", wvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, tx_valid}, 32'd0);
        chk("rst_mid_err", {24'd0, err_count}, 32'd0);
        exp_err = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_quiet", {29'd0, awvalid, wvalid, tx_valid}, 32'd0);
        run_frame('{2'b01, 8'd0, 4'h6, 32'h6000_0008, 32'h0000_0042, 2'b00, 0, 1'b0, 32'h6100, 0});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
